// File: rtl/buffer_w_ctrl.sv
// Fill/drain sequencer for the WEST bridge buffer; optional BUFW_CTRL_STATS_EN adds stall counters.
// Write port is combinational from registers; read data follows bank0_enb by one cycle, out_valid holds under backpressure.
module buffer_w_ctrl #(
    parameter int TOTAL_MODULES = 4,
    parameter int NUM_BEATS     = 3,
    parameter int TOTAL_DEPTH   = 160,
    parameter int READ_PASSES   = 2,
    parameter int ADDR_WIDTH    = $clog2(TOTAL_DEPTH),
    parameter int SIDX_WIDTH    = (TOTAL_MODULES > 1) ? $clog2(TOTAL_MODULES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [SIDX_WIDTH-1:0] slicing_idx,
    output logic                  bank0_ena,
    output logic                  bank0_wea,
    output logic [ADDR_WIDTH-1:0] bank0_addra,
    output logic                  bank0_enb,
    output logic [ADDR_WIDTH-1:0] bank0_addrb,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
`ifdef BUFW_CTRL_STATS_EN
    output logic [31:0]           fill_stall_cnt,
    output logic [31:0]           drain_stall_cnt,
`endif
    output logic                  frame_done
);

    localparam int N      = NUM_BEATS * TOTAL_MODULES;
    localparam int CNT_W  = ($clog2(N + 1) > ADDR_WIDTH) ? $clog2(N + 1) : ADDR_WIDTH;
    localparam int BEAT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int PASS_W = (READ_PASSES > 1) ? $clog2(READ_PASSES) : 1;

    generate
        if (TOTAL_DEPTH < N) begin : g_depth_chk
            $error("buffer_w_ctrl: TOTAL_DEPTH smaller than NUM_BEATS*TOTAL_MODULES");
        end
        if (READ_PASSES < 1) begin : g_pass_chk
            $error("buffer_w_ctrl: READ_PASSES must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [SIDX_WIDTH-1:0]   sidx;
    logic [BEAT_W-1:0]       beat_cnt;
    logic [PASS_W-1:0]       pass_cnt;
    logic [CNT_W-1:0]        rd_addr;
    logic [CNT_W-1:0]        rd_eff;
    logic                    wr_fire;
    logic                    last_slice;
    logic                    more_passes;
    logic                    acc_last;
    logic                    issue;

    assign wr_fire     = (state == FILL) && in_valid;
    assign last_slice  = (sidx == SIDX_WIDTH'(TOTAL_MODULES - 1));
    assign more_passes = (pass_cnt != PASS_W'(READ_PASSES - 1));
    assign acc_last    = out_valid && out_ready && out_last;

    // Restarting the address as the last entry is accepted lets the next pass issue with no bubble.
    assign rd_eff = (acc_last && more_passes) ? '0 : rd_addr;
    assign issue  = (state == DRAIN) && (rd_eff < CNT_W'(N)) && (!out_valid || out_ready);

    assign bank0_ena   = wr_fire;
    assign bank0_wea   = wr_fire;
    assign bank0_addra = wr_addr;
    assign slicing_idx = sidx;
    assign in_ready    = wr_fire && last_slice;
    assign bank0_enb   = issue;
    assign bank0_addrb = issue ? rd_eff[ADDR_WIDTH-1:0] : '0;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_addr    <= '0;
            sidx       <= '0;
            beat_cnt   <= '0;
            pass_cnt   <= '0;
            rd_addr    <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (wr_fire) begin
                        wr_addr <= wr_addr + 1'b1;
                        if (last_slice) begin
                            sidx <= '0;
                            if (beat_cnt == BEAT_W'(NUM_BEATS - 1)) begin
                                beat_cnt <= '0;
                                wr_addr  <= '0;
                                rd_addr  <= '0;
                                pass_cnt <= '0;
                                state    <= DRAIN;
                            end else begin
                                beat_cnt <= beat_cnt + 1'b1;
                            end
                        end else begin
                            sidx <= sidx + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    rd_addr   <= issue ? rd_eff + 1'b1 : rd_eff;
                    out_valid <= issue || (out_valid && !out_ready);
                    if (issue) begin
                        out_last <= (rd_eff == CNT_W'(N - 1));
                    end else if (out_ready) begin
                        out_last <= 1'b0;
                    end
                    if (acc_last) begin
                        if (more_passes) begin
                            pass_cnt <= pass_cnt + 1'b1;
                        end else begin
                            pass_cnt   <= '0;
                            rd_addr    <= '0;
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef BUFW_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_stall_cnt  <= '0;
            drain_stall_cnt <= '0;
        end else if (state == IDLE && in_valid) begin
            fill_stall_cnt  <= '0;
            drain_stall_cnt <= '0;
        end else begin
            if (state == FILL && !in_valid && fill_stall_cnt != '1) begin
                fill_stall_cnt <= fill_stall_cnt + 1'b1;
            end
            if (state == DRAIN && out_valid && !out_ready && drain_stall_cnt != '1) begin
                drain_stall_cnt <= drain_stall_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_buffer_w_ctrl.sv
// Directed bench for buffer_w_ctrl: default instance with a behavioural buffer RAM, plus a 1x1x1 corner instance.
module tb_buffer_w_ctrl;

    localparam int TM = 4;
    localparam int NB = 3;
    localparam int RP = 2;
    localparam int N  = TM * NB;
    localparam int AW = 8;
    localparam int SW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, in_valid, in_ready, bank0_ena, bank0_wea, bank0_enb;
    logic [SW-1:0] slicing_idx;
    logic [AW-1:0] bank0_addra, bank0_addrb;
    logic          out_valid, out_ready, out_last, busy, frame_done;
`ifdef BUFW_CTRL_STATS_EN
    logic [31:0]   fill_stall_cnt, drain_stall_cnt;
    logic [31:0]   fsc1, dsc1;
`endif

    logic          rst1, iv1, ir1, ena1, wea1, enb1, ov1, or1, ol1, busy1, fd1;
    logic [0:0]    sidx1;
    logic [AW-1:0] addra1, addrb1;

    buffer_w_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .slicing_idx(slicing_idx), .bank0_ena(bank0_ena), .bank0_wea(bank0_wea),
        .bank0_addra(bank0_addra), .bank0_enb(bank0_enb), .bank0_addrb(bank0_addrb),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy),
`ifdef BUFW_CTRL_STATS_EN
        .fill_stall_cnt(fill_stall_cnt), .drain_stall_cnt(drain_stall_cnt),
`endif
        .frame_done(frame_done)
    );

    buffer_w_ctrl #(.TOTAL_MODULES(1), .NUM_BEATS(1), .READ_PASSES(1)) u_dut1 (
        .clk(clk), .rst_n(rst1), .in_valid(iv1), .in_ready(ir1),
        .slicing_idx(sidx1), .bank0_ena(ena1), .bank0_wea(wea1),
        .bank0_addra(addra1), .bank0_enb(enb1), .bank0_addrb(addrb1),
        .out_valid(ov1), .out_ready(or1), .out_last(ol1), .busy(busy1),
`ifdef BUFW_CTRL_STATS_EN
        .fill_stall_cnt(fsc1), .drain_stall_cnt(dsc1),
`endif
        .frame_done(fd1)
    );

    // Behavioural buffer: each entry stores {beat tag, slice index}.
    logic [15:0] mem [0:159];
    logic [15:0] dout;
    logic [7:0]  cur_beat;
    logic [7:0]  frame_base;
    always @(posedge clk) begin
        if (bank0_ena && bank0_wea) mem[bank0_addra] <= {cur_beat, 8'(slicing_idx)};
        if (bank0_enb) dout <= mem[bank0_addrb];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_word(input int e);
        return {frame_base + 8'(e / TM), 8'(e % TM)};
    endfunction

    task automatic check_idle_outputs(input string tag);
        check(tag, 32'({in_ready, slicing_idx, bank0_ena, bank0_wea, bank0_addra, bank0_enb,
                        bank0_addrb, out_valid, out_last, busy, frame_done}), 32'd0);
    endtask

    task automatic do_fill(input int gap_after, input int gap_len, input logic [7:0] base);
        int  k   = 0;
        int  gap = 0;
        int  cyc = 0;
        bit  bump = 1'b0;
        @(posedge clk); #1;
        in_valid   = 1'b1;
        cur_beat   = base;
        frame_base = base;
        @(negedge clk);
        check("idle_ena", 32'(bank0_ena), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_frame_done", 32'(frame_done), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd0);
        while (k < N && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (bump) begin
                cur_beat = cur_beat + 8'd1;
                bump = 1'b0;
            end
            if (k == gap_after + 1 && gap < gap_len) begin
                in_valid = 1'b0;
                gap++;
            end else begin
                in_valid = 1'b1;
            end
            @(negedge clk);
            if (in_valid) begin
                check("fill_ena", 32'(bank0_ena), 32'd1);
                check("fill_wea", 32'(bank0_wea), 32'd1);
                check("fill_addra", 32'(bank0_addra), 32'(k));
                check("fill_sidx", 32'(slicing_idx), 32'(k % TM));
                check("fill_in_ready", 32'(in_ready), 32'(k % TM == TM - 1));
                bump = (k % TM == TM - 1);
                k++;
            end else begin
                check("gap_ena", 32'(bank0_ena), 32'd0);
                check("gap_wea", 32'(bank0_wea), 32'd0);
                check("gap_in_ready", 32'(in_ready), 32'd0);
            end
        end
        check("fill_writes", 32'(k), 32'(N));
`ifdef BUFW_CTRL_STATS_EN
        check("fill_stall_cnt", fill_stall_cnt, 32'(gap_len));
`endif
    endtask

    // in_valid stays high throughout, so in_ready must stay low for the whole drain.
    task automatic do_drain(input int stall_at, input int stall_len, input int abort_at);
        int acc = 0;
        int iss = 0;
        int stl = 0;
        int cyc = 0;
        bit done = 1'b0;
        bit prev_stall = 1'b0;
        while (!done && cyc < 400) begin
            @(posedge clk); #1;
            if (abort_at >= 0 && acc == abort_at && out_valid) begin
                rst_n = 1'b0;
                return;
            end
            out_ready = !(acc == stall_at && stl < stall_len && out_valid);
            @(negedge clk);
            cyc++;
            check("drain_in_ready", 32'(in_ready), 32'd0);
            check("drain_ena", 32'(bank0_ena), 32'd0);
            if (prev_stall) check("stall_hold_valid", 32'(out_valid), 32'd1);
            prev_stall = 1'b0;
            if (bank0_enb) begin
                check("drain_addrb", 32'(bank0_addrb), 32'(iss % N));
                iss++;
            end
            if (out_valid) begin
                check("drain_dout", 32'(dout), 32'(exp_word(acc % N)));
                check("drain_last", 32'(out_last), 32'(acc % N == N - 1));
                if (out_ready) begin
                    acc++;
                end else begin
                    stl++;
                    prev_stall = 1'b1;
                    check("stall_enb", 32'(bank0_enb), 32'd0);
                end
            end
            if (frame_done) begin
                done = 1'b1;
                check("drain_cycles", 32'(cyc), 32'(N * RP + 2 + stall_len));
                check("drain_accepted", 32'(acc), 32'(N * RP));
                check("drain_issued", 32'(iss), 32'(N * RP));
                check("done_busy", 32'(busy), 32'd1);
`ifdef BUFW_CTRL_STATS_EN
                check("drain_stall_cnt", drain_stall_cnt, 32'(stall_len));
`endif
            end
        end
        check("drain_completed", 32'(done), 32'd1);
    endtask

    logic [6:0] exp1 [6];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        rst1 = 1'b0; iv1 = 1'b0; or1 = 1'b1;
        cur_beat = 8'd0; frame_base = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_outputs");
`ifdef BUFW_CTRL_STATS_EN
        check("reset_stats", fill_stall_cnt | drain_stall_cnt, 32'd0);
`endif

        // Frame A: 2-cycle input gap after addra 5, then 3-cycle output stall on entry 4.
        do_fill(5, 2, 8'h10);
        do_drain(4, 3, -1);
        // Frame B: no stalls; stall counters must restart from zero.
        do_fill(-9, 0, 8'h20);
        do_drain(-1, 0, -1);
        // Frame C: reset while entry 7 of the second pass is valid.
        do_fill(-9, 0, 8'h30);
        do_drain(-1, 0, N + 7);
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check_idle_outputs("abort_outputs");
        // Frame D: fresh frame after the abort refills from address 0.
        do_fill(-9, 0, 8'h40);
        do_drain(-1, 0, -1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("final_busy", 32'(busy), 32'd0);
        check("final_frame_done", 32'(frame_done), 32'd0);

        // Single-entry instance: {ena, in_ready, enb, out_valid, out_last, frame_done, busy} per cycle.
        exp1[0] = 7'b0000000;
        exp1[1] = 7'b1100001;
        exp1[2] = 7'b0010001;
        exp1[3] = 7'b0001101;
        exp1[4] = 7'b0000011;
        exp1[5] = 7'b0000000;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            rst1 = 1'b1;
            iv1  = (c < 2);
            @(negedge clk);
            check($sformatf("single_cycle%0d", c), 32'({ena1, ir1, enb1, ov1, ol1, fd1, busy1}), 32'(exp1[c]));
            if (c == 1) check("single_write", 32'({wea1, addra1, sidx1}), 32'h200);
            if (c == 2) check("single_read_addr", 32'(addrb1), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
